// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM encoding for the push-button debouncer
package key_debounce_pkg;
  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_IDLE_HIGH = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_t;
endpackage

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] r_sync;
  // shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[0], d};
  assign q = r_sync[1];
endmodule

// File: rtl/key_debounce.sv
// key_debounce: qualifies a synchronized push-button level over STABLE_CYCLES cycles
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 400000,
  parameter int CNT_W         = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_debounced,
  output logic busy
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  logic             w_s;
  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_pb, w_nxt_pb;
  logic             r_busy, w_nxt_busy;
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pb_in),
    .q     (w_s)
  );
  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE_LOW;
      r_cnt   <= '0;
      r_pb    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_pb    <= w_nxt_pb;
      r_busy  <= w_nxt_busy;
    end
  // next-state: a candidate level must persist until the counter hits its last value
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = '0;
    w_nxt_pb    = r_pb;
    case (r_state)
      ST_IDLE_LOW:  w_nxt_state = w_s ? ST_WAIT_HIGH : ST_IDLE_LOW;
      ST_WAIT_HIGH:
        if (!w_s) w_nxt_state = ST_IDLE_LOW;
        else if (r_cnt == LP_LAST) begin
          w_nxt_state = ST_IDLE_HIGH;
          w_nxt_pb    = 1'b1;
        end else w_nxt_cnt = r_cnt + CNT_W'(1);
      ST_IDLE_HIGH: w_nxt_state = w_s ? ST_IDLE_HIGH : ST_WAIT_LOW;
      ST_WAIT_LOW:
        if (w_s) w_nxt_state = ST_IDLE_HIGH;
        else if (r_cnt == LP_LAST) begin
          w_nxt_state = ST_IDLE_LOW;
          w_nxt_pb    = 1'b0;
        end else w_nxt_cnt = r_cnt + CNT_W'(1);
      default: begin
        w_nxt_state = ST_IDLE_LOW;
        w_nxt_pb    = 1'b0;
      end
    endcase
    w_nxt_busy = (w_nxt_state == ST_WAIT_HIGH) || (w_nxt_state == ST_WAIT_LOW);
  end
  assign pb_debounced = r_pb;
  assign busy         = r_busy;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized scoreboard bench against a run-length reference model
module tb_key_debounce;
  localparam int S = 4;
  localparam int W = 3;
  typedef struct packed {
    bit deb;
    bit busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb_in = 1'b0;
  logic pb_debounced;
  logic busy;
  int n_checks = 0;
  int n_pass = 0;
  bit m_deb;
  int m_run;
  bit hist[$];
  exp_t exp_q[$];
  bit bt[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  bit lv;
  int len;

  key_debounce #(.STABLE_CYCLES(S), .CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_in        (pb_in),
    .pb_debounced (pb_debounced),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // The debouncer sees each pb_in sample two edges late; the level flips
  // once S+1 consecutive seen samples disagree with the current level.
  function automatic void model_reset();
    m_deb = 1'b0;
    m_run = 0;
    hist = '{1'b0, 1'b0};
    exp_q.delete();
  endfunction

  task automatic step(input bit v);
    bit seen;
    pb_in = v;
    hist.push_back(v);
    seen = hist[0];
    void'(hist.pop_front());
    m_run = (seen != m_deb) ? m_run + 1 : 0;
    if (m_run == S + 1) begin
      m_deb = ~m_deb;
      m_run = 0;
    end
    exp_q.push_back({m_deb, m_run != 0});
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pb", pb_debounced, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", dut.r_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pb_debounced", pb_debounced, e.deb);
        chk("busy", busy, e.busy);
        chk("cnt_bound", (dut.r_cnt <= W'(S - 1)) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pb", pb_debounced, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", dut.r_cnt, 0);
    rst_n = 1'b1;
    repeat (20) step(1'b0);
    repeat (S + 8) step(1'b1);
    repeat (10) step(1'b0);
    repeat (3) step(1'b1);
    repeat (8) step(1'b0);
    foreach (bt[i]) step(bt[i]);
    repeat (10) step(1'b1);
    repeat (10) step(1'b0);
    for (int i = 0; i < 10 && m_run != 3; i++) step(1'b1);
    chk("mid_qual_busy", busy, 1);
    pulse_reset();
    repeat (S + 6) step(1'b1);
    chk("post_reset_rise", pb_debounced, 1);
    for (int i = 0; i < 250; i++) begin
      lv = 1'($urandom_range(0, 1));
      len = $urandom_range(1, S + 3);
      repeat (len) step(lv);
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
